// File: rtl/proc_pkg.sv
// Shared processor definitions: completion FSM states and instruction constants.
package proc_pkg;

  // Instruction width used by the fetch path.
  localparam int INSTR_W = 9;

  // Instruction encoding that ends a program.
  localparam logic [INSTR_W-1:0] HALT_OP_DEFAULT = 9'h1FF;

  // Host handshake completion states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } done_state_t;

endpackage

// File: rtl/sat_cycle_counter.sv
// Saturating cycle counter with clear/enable and a look-ahead terminal flag.
// Terminal is high when the next enabled increment lands on MAX_CYCLES, so the
// owner can act on the same edge that makes Count reach the limit.
module sat_cycle_counter #(
  parameter int            CW         = 16,
  parameter logic [CW-1:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Clear,
  input  logic          Enable,
  output logic [CW-1:0] Count,
  output logic          Terminal
);

  localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
  localparam logic [CW-1:0] CNT_LAST = MAX_CYCLES - CNT_ONE;

  logic [CW-1:0] count_r;

  // Count enabled cycles; clear wins, and the value never passes MAX_CYCLES.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count_r <= '0;
    end else if (Clear) begin
      count_r <= '0;
    end else if (Enable && (count_r != MAX_CYCLES)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign Count    = count_r;
  assign Terminal = (count_r == CNT_LAST);

endmodule

// File: rtl/prog_done_ctrl.sv
// Completion side of the host Start/Done handshake: tracks a program from the
// Start release through halt, timeout or abort, with registered status outputs.
module prog_done_ctrl
  import proc_pkg::*;
#(
  parameter int               L          = 10,
  parameter int               W          = INSTR_W,
  parameter logic [W-1:0]     HALT_OP    = HALT_OP_DEFAULT,
  parameter int               CW         = 16,
  parameter logic [CW-1:0]    MAX_CYCLES = 16'hFFFF,
  parameter int               NP         = 4,
  localparam int              PW         = (NP > 1) ? $clog2(NP) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [W-1:0]  Instr,
  input  logic [L-1:0]  ProgCtr,
  output logic          Done,
  output logic          Running,
  output logic          Timeout,
  output logic [PW-1:0] ProgIdx,
  output logic [CW-1:0] CycleCount,
  output logic [L-1:0]  HaltPC
);

  localparam logic [PW-1:0] IDX_LAST = PW'(NP - 1);
  localparam logic [PW-1:0] IDX_ONE  = PW'(32'd1);

  done_state_t   state_r;
  done_state_t   state_nxt_s;
  logic          cnt_clr_s;
  logic          cnt_en_s;
  logic          cnt_term_s;
  logic          halt_s;
  logic          done_r;
  logic          running_r;
  logic          timeout_r;
  logic [PW-1:0] prog_idx_r;
  logic [L-1:0]  halt_pc_r;

  assign halt_s = (Instr == HALT_OP);

  sat_cycle_counter #(
    .CW         (CW),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cycle_cnt (
    .Clk      (Clk),
    .Reset    (Reset),
    .Clear    (cnt_clr_s),
    .Enable   (cnt_en_s),
    .Count    (CycleCount),
    .Terminal (cnt_term_s)
  );

  // Next state and counter controls; abort beats halt, halt beats timeout.
  always_comb begin
    state_nxt_s = state_r;
    cnt_clr_s   = 1'b0;
    cnt_en_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (Start) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARMED: begin
        if (Start) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = RUN;
          cnt_clr_s   = 1'b1;
        end
      end
      RUN: begin
        cnt_en_s = 1'b1;
        if (Start) begin
          state_nxt_s = ARMED;
        end else if (halt_s) begin
          state_nxt_s = DONE;
        end else if (cnt_term_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (Start) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered host-visible status, updated on the transitions that own them.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      done_r     <= 1'b0;
      running_r  <= 1'b0;
      timeout_r  <= 1'b0;
      prog_idx_r <= IDX_LAST;
      halt_pc_r  <= '0;
    end else begin
      running_r <= (state_nxt_s == RUN);
      case (state_r)
        ARMED: begin
          if (!Start) begin
            prog_idx_r <= (prog_idx_r == IDX_LAST) ? '0 : (prog_idx_r + IDX_ONE);
            done_r     <= 1'b0;
            timeout_r  <= 1'b0;
          end
        end
        RUN: begin
          if (Start) begin
            done_r <= 1'b0;
          end else if (halt_s) begin
            done_r    <= 1'b1;
            timeout_r <= 1'b0;
            halt_pc_r <= ProgCtr;
          end else if (cnt_term_s) begin
            done_r    <= 1'b1;
            timeout_r <= 1'b1;
            halt_pc_r <= ProgCtr;
          end
        end
        DONE: begin
          if (Start) begin
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
          end
        end
        default: begin
          done_r <= done_r;
        end
      endcase
    end
  end

  assign Done    = done_r;
  assign Running = running_r;
  assign Timeout = timeout_r;
  assign ProgIdx = prog_idx_r;
  assign HaltPC  = halt_pc_r;

endmodule

// File: tb/tb_prog_done_ctrl.sv
// Self-checking bench for prog_done_ctrl: a vector table, directed corner
// sequences and randomized traffic compared against a behavioural model.
module tb_prog_done_ctrl;

  localparam int            L      = 10;
  localparam int            W      = 9;
  localparam int            CW     = 16;
  localparam int            NP     = 4;
  localparam int            TB_MAX = 8;
  localparam logic [W-1:0]  HALT   = 9'h1FF;
  localparam logic [W-1:0]  NOP    = 9'h000;

  logic          Clk = 1'b0;
  logic          Reset = 1'b0;
  logic          Start = 1'b0;
  logic [W-1:0]  Instr = '0;
  logic [L-1:0]  ProgCtr = '0;
  logic          Done;
  logic          Running;
  logic          Timeout;
  logic [1:0]    ProgIdx;
  logic [CW-1:0] CycleCount;
  logic [L-1:0]  HaltPC;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: a program is either waiting for Start release,
  // running, or neither (idle or finished, distinguished only by m_done).
  bit m_armed, m_run, m_done, m_to;
  int m_idx, m_cnt, m_hpc;

  prog_done_ctrl #(
    .L(L), .W(W), .HALT_OP(HALT), .CW(CW), .MAX_CYCLES(16'd8), .NP(NP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr), .ProgCtr(ProgCtr),
    .Done(Done), .Running(Running), .Timeout(Timeout), .ProgIdx(ProgIdx),
    .CycleCount(CycleCount), .HaltPC(HaltPC)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic          start;
    logic [W-1:0]  instr;
    logic [L-1:0]  pc;
    logic          done;
    logic          running;
    logic          timeout;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic [L-1:0]  hpc;
  } vec_t;

  vec_t vec [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 1'b0; m_run = 1'b0; m_done = 1'b0; m_to = 1'b0;
    m_idx = NP - 1; m_cnt = 0; m_hpc = 0;
  endtask

  task automatic model_edge(input logic s, input logic [W-1:0] ins, input logic [L-1:0] pc);
    if (m_run) begin
      m_cnt = m_cnt + 1;
      if (s) begin
        m_run = 1'b0; m_armed = 1'b1;
      end else if (ins == HALT) begin
        m_run = 1'b0; m_done = 1'b1; m_to = 1'b0; m_hpc = int'(pc);
      end else if (m_cnt == TB_MAX) begin
        m_run = 1'b0; m_done = 1'b1; m_to = 1'b1; m_hpc = int'(pc);
      end
    end else if (m_armed) begin
      if (!s) begin
        m_armed = 1'b0; m_run = 1'b1; m_cnt = 0;
        m_idx = (m_idx + 1) % NP; m_done = 1'b0; m_to = 1'b0;
      end
    end else if (s) begin
      m_armed = 1'b1; m_done = 1'b0; m_to = 1'b0;
    end
  endtask

  task automatic check_model();
    chk("model_done",    32'(Done),       32'(m_done));
    chk("model_running", 32'(Running),    32'(m_run));
    chk("model_timeout", 32'(Timeout),    32'(m_to));
    chk("model_idx",     32'(ProgIdx),    32'(m_idx));
    chk("model_cnt",     32'(CycleCount), 32'(m_cnt));
    chk("model_hpc",     32'(HaltPC),     32'(m_hpc));
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic step(input logic s, input logic [W-1:0] ins, input logic [L-1:0] pc);
    Start = s; Instr = ins; ProgCtr = pc;
    @(posedge Clk);
    model_edge(s, ins, pc);
    #1;
    check_model();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_done"},    32'(Done),       32'd0);
    chk({tag, "_running"}, 32'(Running),    32'd0);
    chk({tag, "_timeout"}, 32'(Timeout),    32'd0);
    chk({tag, "_idx"},     32'(ProgIdx),    32'(NP - 1));
    chk({tag, "_cnt"},     32'(CycleCount), 32'd0);
    chk({tag, "_hpc"},     32'(HaltPC),     32'd0);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1; Start = 1'b0; Instr = NOP; ProgCtr = '0;
    #1;
    check_reset_values("rst");
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    #1;
  endtask

  initial begin
    // Start held 3 cycles, 4 NOP edges, HALT at pc 7, then held in DONE.
    vec[0]  = '{1'b1, NOP,  10'd0, 1'b0, 1'b0, 1'b0, 2'd3, 16'd0, 10'd0};
    vec[1]  = '{1'b1, NOP,  10'd0, 1'b0, 1'b0, 1'b0, 2'd3, 16'd0, 10'd0};
    vec[2]  = '{1'b1, NOP,  10'd0, 1'b0, 1'b0, 1'b0, 2'd3, 16'd0, 10'd0};
    vec[3]  = '{1'b0, NOP,  10'd0, 1'b0, 1'b1, 1'b0, 2'd0, 16'd0, 10'd0};
    vec[4]  = '{1'b0, NOP,  10'd1, 1'b0, 1'b1, 1'b0, 2'd0, 16'd1, 10'd0};
    vec[5]  = '{1'b0, NOP,  10'd2, 1'b0, 1'b1, 1'b0, 2'd0, 16'd2, 10'd0};
    vec[6]  = '{1'b0, NOP,  10'd3, 1'b0, 1'b1, 1'b0, 2'd0, 16'd3, 10'd0};
    vec[7]  = '{1'b0, NOP,  10'd4, 1'b0, 1'b1, 1'b0, 2'd0, 16'd4, 10'd0};
    vec[8]  = '{1'b0, HALT, 10'd7, 1'b1, 1'b0, 1'b0, 2'd0, 16'd5, 10'd7};
    vec[9]  = '{1'b0, NOP,  10'd9, 1'b1, 1'b0, 1'b0, 2'd0, 16'd5, 10'd7};
    vec[10] = '{1'b0, HALT, 10'd3, 1'b1, 1'b0, 1'b0, 2'd0, 16'd5, 10'd7};

    model_reset();
    Reset = 1'b1;
    #12;
    check_reset_values("por");
    @(negedge Clk);
    Reset = 1'b0;
    #1;

    // HALT while IDLE and ARMED is ignored.
    step(1'b0, HALT, 10'd5);
    chk("idle_halt_done", 32'(Done), 32'd0);
    chk("idle_halt_idx",  32'(ProgIdx), 32'd3);
    step(1'b1, HALT, 10'd5);
    chk("armed_halt_done", 32'(Done), 32'd0);
    chk("armed_halt_run",  32'(Running), 32'd0);
    do_reset();

    // Table-driven nominal program.
    for (int i = 0; i < 11; i++) begin
      step(vec[i].start, vec[i].instr, vec[i].pc);
      chk("tbl_done",    32'(Done),       32'(vec[i].done));
      chk("tbl_running", 32'(Running),    32'(vec[i].running));
      chk("tbl_timeout", 32'(Timeout),    32'(vec[i].timeout));
      chk("tbl_idx",     32'(ProgIdx),    32'(vec[i].idx));
      chk("tbl_cnt",     32'(CycleCount), 32'(vec[i].cnt));
      chk("tbl_hpc",     32'(HaltPC),     32'(vec[i].hpc));
    end

    // Timeout at MAX_CYCLES with no HALT; single-cycle Start from DONE.
    step(1'b1, NOP, 10'd0);
    chk("to_start_clears_done", 32'(Done), 32'd0);
    chk("to_start_keeps_cnt",   32'(CycleCount), 32'd5);
    step(1'b0, NOP, 10'd0);
    for (int i = 1; i <= TB_MAX; i++) step(1'b0, NOP, 10'(20 + i));
    chk("to_done",    32'(Done),       32'd1);
    chk("to_timeout", 32'(Timeout),    32'd1);
    chk("to_cnt",     32'(CycleCount), 32'd8);
    chk("to_hpc",     32'(HaltPC),     32'd28);

    // HALT on the MAX_CYCLES edge wins over timeout.
    step(1'b1, NOP, 10'd0);
    step(1'b0, NOP, 10'd0);
    for (int i = 1; i < TB_MAX; i++) step(1'b0, NOP, 10'(i));
    step(1'b0, HALT, 10'd99);
    chk("halt8_done",    32'(Done),       32'd1);
    chk("halt8_timeout", 32'(Timeout),    32'd0);
    chk("halt8_cnt",     32'(CycleCount), 32'd8);
    chk("halt8_hpc",     32'(HaltPC),     32'd99);

    // Abort with Start after 3 RUN edges, then restart.
    step(1'b1, NOP, 10'd0);
    step(1'b0, NOP, 10'd0);
    for (int i = 0; i < 3; i++) step(1'b0, NOP, 10'(i));
    step(1'b1, HALT, 10'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_run",  32'(Running), 32'd0);
    chk("abort_cnt",  32'(CycleCount), 32'd4);
    step(1'b0, NOP, 10'd0);
    chk("abort_restart_cnt", 32'(CycleCount), 32'd0);
    chk("abort_restart_idx", 32'(ProgIdx), 32'd0);
    chk("abort_restart_run", 32'(Running), 32'd1);
    step(1'b0, HALT, 10'd1);
    chk("first_cycle_halt_cnt", 32'(CycleCount), 32'd1);

    // NP+1 back-to-back halted programs from reset: ProgIdx 0,1,2,3,0.
    do_reset();
    for (int p = 0; p <= NP; p++) begin
      step(1'b1, NOP, 10'd0);
      chk("seq_start_done", 32'(Done), 32'd0);
      step(1'b0, NOP, 10'd0);
      chk("seq_idx", 32'(ProgIdx), 32'(p % NP));
      step(1'b0, NOP, 10'd1);
      step(1'b0, HALT, 10'(p + 40));
      for (int k = 0; k < 2; k++) begin
        step(1'b0, NOP, 10'd0);
        chk("seq_done_stable", 32'(Done), 32'd1);
        chk("seq_cnt_stable",  32'(CycleCount), 32'd2);
      end
    end

    // Asynchronous reset mid-RUN.
    step(1'b1, NOP, 10'd0);
    step(1'b0, NOP, 10'd0);
    step(1'b0, NOP, 10'd1);
    step(1'b0, NOP, 10'd2);
    #2;
    Reset = 1'b1;
    #1;
    check_reset_values("midrun");
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    #1;

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      logic s;
      logic [W-1:0] ins;
      s   = ($urandom_range(0, 7) == 0);
      ins = ($urandom_range(0, 5) == 0) ? HALT : W'($urandom_range(0, 510));
      step(s, ins, L'($urandom_range(0, 1023)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
